// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: main control FSM for the multicycle ARM-subset CPU.
// Optional performance counters are enabled with CTRL_PERF_CNT_EN.
module multicycle_ctrl_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               mem_ready,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               ALUOp,
    output logic               NextPC,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_o
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instr_cnt
`endif
);
    typedef enum logic [STATE_W-1:0] {
        IDLE    = 'd0,
        FETCH   = 'd1,
        DECODE  = 'd2,
        MEMADR  = 'd3,
        MEMRD   = 'd4,
        MEMWB   = 'd5,
        MEMWR   = 'd6,
        EXECR   = 'd7,
        EXECI   = 'd8,
        ALUWB   = 'd9,
        BRANCH  = 'd10,
        ILLEGAL = 'd11
    } state_t;

    state_t state_q, state_d;
    logic   unused_funct;

    assign unused_funct = ^Funct[4:1];
    assign state_o      = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = IDLE;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUOp      = 1'b0;
        NextPC     = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        Branch     = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                NextPC    = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // PC+4 computed again here yields PC+8 for R15 operand reads
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = Op == 2'b01 ? MEMADR :
                            Op == 2'b10 ? BRANCH :
                            Op == 2'b11 ? ILLEGAL :
                            Funct[5]    ? EXECI : EXECR;
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                state_d   = FETCH;
            end
            MEMWR: begin
                AdrSrc  = 1'b1;
                MemW    = 1'b1;
                state_d = mem_ready ? FETCH : MEMWR;
            end
            EXECR: begin
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegW    = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
                state_d   = FETCH;
            end
            ILLEGAL: begin
                illegal_op = 1'b1;
                state_d    = ILLEGAL;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_q, instr_q;
    logic        cyc_inc, ins_inc;

    assign cyc_inc   = state_q != IDLE && state_q != ILLEGAL;
    assign ins_inc   = state_d == FETCH && (state_q == MEMWB || state_q == MEMWR ||
                                            state_q == ALUWB || state_q == BRANCH);
    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q <= 32'd0;
            instr_q <= 32'd0;
        end else begin
            cycle_q <= cycle_q + 32'(cyc_inc);
            instr_q <= instr_q + 32'(ins_inc);
        end
    end
`endif
endmodule
